// File: rtl/chess_pkg.sv
// Shared FSM encoding and default geometry for the checkerboard scan generator.
package chess_pkg;
  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  localparam int unsigned DEF_H_ACT = 800;
  localparam int unsigned DEF_V_ACT = 800;
  localparam int unsigned DEF_SQ    = 100;
endpackage

// File: rtl/chess_scan_if.sv
// Pixel stream: a pixel moves on any cycle with PIX_VALID=1 and PIX_READY=1; while
// PIX_VALID=1 and PIX_READY=0 every pixel field holds; PIX_READY is ignored when PIX_VALID=0.
interface chess_scan_if;
  logic       PIX_VALID;
  logic       PIX_READY;
  logic       PIX_DATA;
  logic [9:0] PIX_X;
  logic [9:0] PIX_Y;
  logic       SOF;
  logic       EOL;

  modport master (output PIX_VALID, PIX_DATA, PIX_X, PIX_Y, SOF, EOL, input PIX_READY);
  modport slave  (input PIX_VALID, PIX_DATA, PIX_X, PIX_Y, SOF, EOL, output PIX_READY);
endinterface

// File: rtl/chess_axis_cnt.sv
// One axis of the scan: position counter, square sub-counter and square-parity bit.
module chess_axis_cnt
  import chess_pkg::*;
#(
  parameter int unsigned MAX = DEF_H_ACT,
  parameter int unsigned SQ  = DEF_SQ
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [9:0] pos,
  output logic       last,
  output logic       par
);
  localparam int unsigned SUB_W = (SQ > 1) ? $clog2(SQ) : 1;

  logic [SUB_W-1:0] sub;
  logic             sub_last;

  assign last     = (pos == 10'(MAX - 1));
  assign sub_last = (sub == SUB_W'(SQ - 1));

  // Parity flips each time the sub-counter wraps, so it tracks (pos div SQ) mod 2.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      pos <= '0;
      sub <= '0;
      par <= 1'b0;
    end else if (inc) begin
      if (last) begin
        pos <= '0;
        sub <= '0;
        par <= 1'b0;
      end else begin
        pos <= pos + 10'd1;
        if (sub_last) begin
          sub <= '0;
          par <= ~par;
        end else begin
          sub <= sub + SUB_W'(1);
        end
      end
    end
  end
endmodule

// File: rtl/chess_scan.sv
// Checkerboard frame generator: raster-scans one frame per EN request onto a
// valid/ready pixel stream and pulses FRAME_DONE once after the last pixel.
module chess_scan
  import chess_pkg::*;
#(
  parameter int unsigned H_ACT  = DEF_H_ACT,
  parameter int unsigned V_ACT  = DEF_V_ACT,
  parameter int unsigned SQ     = DEF_SQ,
  parameter bit          INVERT = 1'b0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EN,
  chess_scan_if.master  pix,
  output logic          BUSY,
  output logic          FRAME_DONE,
  output state_t        dbg_state
);
  state_t     state;
  logic       run;
  logic       xfer;
  logic [9:0] x_pos, y_pos;
  logic       x_last, y_last, x_par, y_par;

  assign run  = (state == ST_RUN);
  assign xfer = run & pix.PIX_READY;

  // Counters are held at zero outside RUN, so every frame starts from (0,0).
  chess_axis_cnt #(.MAX(H_ACT), .SQ(SQ)) u_x_cnt (
    .clk(CLK), .rst_n(RST), .clr(~run), .inc(xfer),
    .pos(x_pos), .last(x_last), .par(x_par)
  );

  chess_axis_cnt #(.MAX(V_ACT), .SQ(SQ)) u_y_cnt (
    .clk(CLK), .rst_n(RST), .clr(~run), .inc(xfer & x_last),
    .pos(y_pos), .last(y_last), .par(y_par)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (EN) state <= ST_RUN;
        ST_RUN:  if (xfer && x_last && y_last) state <= ST_DONE;
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign pix.PIX_VALID = run;
  assign pix.PIX_DATA  = run & (x_par ^ y_par ^ INVERT);
  assign pix.PIX_X     = run ? x_pos : 10'd0;
  assign pix.PIX_Y     = run ? y_pos : 10'd0;
  assign pix.SOF       = run & (x_pos == 10'd0) & (y_pos == 10'd0);
  assign pix.EOL       = run & x_last;
  assign BUSY          = (state != ST_IDLE);
  assign FRAME_DONE    = (state == ST_DONE);
  assign dbg_state     = state;
endmodule

// File: tb/tb_chess_scan.sv
// Bench for chess_scan: a reduced-geometry frame model with an expected-pixel queue,
// compared every cycle against a normal and an inverted instance.
module tb_chess_scan;
  import chess_pkg::*;

  localparam int H    = 80;
  localparam int V    = 60;
  localparam int SQ   = 20;
  localparam int NPIX = H * V;
  localparam int W    = 26;

  logic   CLK = 1'b0;
  logic   RST = 1'b0;
  logic   EN = 1'b0;
  logic   READY = 1'b0;
  logic   busy0, busy1, done0, done1;
  state_t st0, st1;

  int checks = 0;
  int errors = 0;

  chess_scan_if pix0 ();
  chess_scan_if pix1 ();
  assign pix0.PIX_READY = READY;
  assign pix1.PIX_READY = READY;

  chess_scan #(.H_ACT(H), .V_ACT(V), .SQ(SQ), .INVERT(1'b0)) dut0 (
    .CLK(CLK), .RST(RST), .EN(EN), .pix(pix0),
    .BUSY(busy0), .FRAME_DONE(done0), .dbg_state(st0)
  );

  chess_scan #(.H_ACT(H), .V_ACT(V), .SQ(SQ), .INVERT(1'b1)) dut1 (
    .CLK(CLK), .RST(RST), .EN(EN), .pix(pix1),
    .BUSY(busy1), .FRAME_DONE(done1), .dbg_state(st1)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- reference model helpers ----------------
  function automatic logic colour(input int x, input int y, input logic inv);
    return logic'(((x / SQ) + (y / SQ)) % 2) ^ inv;
  endfunction

  // Pixel word {data, sof, eol, y, x} for the k-th pixel of a frame (INVERT=0).
  function automatic logic [22:0] pix_word(input int k);
    int x, y;
    x = k % H;
    y = k / H;
    return {colour(x, y, 1'b0), logic'(k == 0), logic'(x == H - 1), 10'(y), 10'(x)};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  int          mode = 0;             // 0 idle, 1 streaming, 2 frame-done cycle
  logic [22:0] exp_q[$];
  int          sof_cnt = 0;
  int          eol_cnt = 0;
  logic        seen0 [0:H-1][0:V-1];
  logic        seen1 [0:H-1][0:V-1];

  always @(negedge CLK) begin
    logic [22:0]  p;
    logic [W-1:0] e0, e1, a0, a1;
    p  = (mode == 1 && exp_q.size() > 0) ? exp_q[0] : 23'd0;
    e0 = {logic'(mode == 1), logic'(mode != 0), logic'(mode == 2), p};
    e1 = e0;
    e1[22] = p[22] ^ logic'(mode == 1);
    a0 = {pix0.PIX_VALID, busy0, done0, pix0.PIX_DATA, pix0.SOF, pix0.EOL, pix0.PIX_Y, pix0.PIX_X};
    a1 = {pix1.PIX_VALID, busy1, done1, pix1.PIX_DATA, pix1.SOF, pix1.EOL, pix1.PIX_Y, pix1.PIX_X};
    check("outputs_inv0", a0, e0);
    check("outputs_inv1", a1, e1);

    if (mode == 2) begin
      check("eol_count", W'(eol_cnt), W'(V));
      check("sof_count", W'(sof_cnt), W'(1));
    end

    if (!RST) begin
      mode = 0;
      exp_q.delete();
      sof_cnt = 0;
      eol_cnt = 0;
    end else begin
      case (mode)
        0: if (EN) begin
          mode = 1;
          sof_cnt = 0;
          eol_cnt = 0;
          for (int k = 0; k < NPIX; k++) exp_q.push_back(pix_word(k));
        end
        1: if (READY) begin
          if (pix0.PIX_X < 10'(H) && pix0.PIX_Y < 10'(V)) begin
            seen0[pix0.PIX_X][pix0.PIX_Y] = pix0.PIX_DATA;
            seen1[pix0.PIX_X][pix0.PIX_Y] = pix1.PIX_DATA;
          end
          if (pix0.SOF) sof_cnt++;
          if (pix0.EOL) eol_cnt++;
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) mode = 2;
        end
        default: mode = 0;
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic rnd_ready, input logic rnd_en);
    @(posedge CLK);
    #1;
    READY = rnd_ready ? logic'($urandom_range(0, 1)) : 1'b1;
    if (rnd_en) EN = logic'($urandom_range(0, 1));
  endtask

  task automatic pulse_en();
    @(posedge CLK);
    #1 EN = 1'b1;
    @(posedge CLK);
    #1 EN = 1'b0;
  endtask

  task automatic run_to_done(input string tag, input logic rnd_ready, input logic rnd_en);
    int cyc;
    cyc = 0;
    while (!done0 && cyc < 8 * NPIX) begin
      step(rnd_ready, rnd_en);
      cyc++;
    end
    if (!done0) begin
      errors++;
      checks++;
      $display("FAIL %s_timeout: got no FRAME_DONE expected one within %0d cycles", tag, 8 * NPIX);
    end
    EN = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int cyc;
    cyc = 0;
    while (busy0 && cyc < 8 * NPIX) begin
      step(1'b1, 1'b0);
      cyc++;
    end
    checks++;
    if (busy0) begin
      errors++;
      $display("FAIL %s_idle_timeout: got BUSY=1 expected 0", tag);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n_valid, n_gap, cyc;

    // Reset with READY wiggling: outputs must stay zero.
    repeat (4) begin
      @(posedge CLK);
      #1 READY = logic'($urandom_range(0, 1));
    end
    RST = 1'b1;
    repeat (3) step(1'b1, 1'b0);

    // Full-rate frame: every cycle from RUN entry to last pixel transfers.
    READY = 1'b1;
    pulse_en();
    n_valid = 0;
    n_gap = 0;
    cyc = 0;
    while (cyc < 2 * NPIX) begin
      @(negedge CLK);
      cyc++;
      if (done0) break;
      if (pix0.PIX_VALID) n_valid++;
      else n_gap++;
    end
    check("fullrate_pixels", W'(n_valid), W'(NPIX));
    check("fullrate_gaps", W'(n_gap), W'(0));
    @(posedge CLK);
    #1;
    check("busy_after_done", W'(busy0), W'(0));

    // Hand-computed colours pin both the model and the observed stream.
    check("model_0_0", W'(colour(0, 0, 1'b0)), W'(0));
    check("model_19_0", W'(colour(19, 0, 1'b0)), W'(0));
    check("model_20_0", W'(colour(20, 0, 1'b0)), W'(1));
    check("model_20_20", W'(colour(20, 20, 1'b0)), W'(0));
    check("model_79_59", W'(colour(79, 59, 1'b0)), W'(1));
    check("dut_0_0", W'(seen0[0][0]), W'(0));
    check("dut_19_0", W'(seen0[19][0]), W'(0));
    check("dut_20_0", W'(seen0[20][0]), W'(1));
    check("dut_20_20", W'(seen0[20][20]), W'(0));
    check("dut_79_59", W'(seen0[79][59]), W'(1));
    check("inv_0_0", W'(seen1[0][0]), W'(1));
    check("inv_20_0", W'(seen1[20][0]), W'(0));
    check("inv_79_59", W'(seen1[79][59]), W'(0));

    // Random back-pressure, EN toggling mid-frame.
    pulse_en();
    run_to_done("stall", 1'b1, 1'b1);
    wait_idle("stall");

    // Reset in the middle of a frame, then restart from (0,0).
    EN = 1'b1;
    step(1'b1, 1'b0);
    EN = 1'b0;
    cyc = 0;
    while (!(pix0.PIX_VALID && pix0.PIX_X == 10'd35 && pix0.PIX_Y == 10'd41) && cyc < 8 * NPIX) begin
      step(1'b1, 1'b0);
      cyc++;
    end
    check("reach_35_41", {W-20{1'b0}} | {pix0.PIX_Y, pix0.PIX_X}, {W-20{1'b0}} | {10'd41, 10'd35});
    RST = 1'b0;
    @(posedge CLK);
    #1 RST = 1'b1;
    check("midreset_busy", W'(busy0), W'(0));
    pulse_en();
    run_to_done("restart", 1'b1, 1'b0);
    wait_idle("restart");

    // EN held high across DONE: back-to-back frames from IDLE.
    EN = 1'b1;
    step(1'b1, 1'b0);
    run_to_done("held_a", 1'b1, 1'b0);
    EN = 1'b1;
    step(1'b1, 1'b0);
    run_to_done("held_b", 1'b1, 1'b0);
    EN = 1'b0;
    wait_idle("held");
    repeat (4) step(1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
